// File: rtl/gt_frame_pkg.sv
// Shared types and constants for the GT frame generator and the RX frame checker.
package gt_frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSop,
    StPayload
  } gt_state_e;

  // PRBS-31, x^31 + x^28 + 1: feedback taps on state bits 30 and 27.
  localparam int unsigned     PRBS_TAP_HI       = 30;
  localparam int unsigned     PRBS_TAP_LO       = 27;
  localparam logic [30:0]     PRBS_DEFAULT_SEED = 31'h7FFF_FFFF;

  localparam logic [63:0]     SOP_CHAR_DEFAULT  = 64'h0000_0000_0000_00fb;
  localparam logic [63:0]     IDLE_CHAR_DEFAULT = 64'h0000_0000_0000_00bc;

endpackage

// File: rtl/gt_frame_gen_prbs31_par.sv
// Registered parallel PRBS-31 LFSR: word_o is the next TX_DATA_WIDTH serial bits, bit 0 first.
module gt_prbs31_par
  import gt_frame_pkg::*;
#(
  parameter int unsigned TX_DATA_WIDTH = 64,
  parameter logic [30:0] PRBS_SEED     = PRBS_DEFAULT_SEED
) (
  input  logic                     USER_CLK,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     advance_i,
  output logic [TX_DATA_WIDTH-1:0] word_o
);

  logic [30:0] lfsr_q;
  logic [30:0] lfsr_adv;
  logic        fb;

  always_comb begin
    lfsr_adv = lfsr_q;
    fb       = 1'b0;
    word_o   = '0;
    for (int i = 0; i < int'(TX_DATA_WIDTH); i++) begin
      fb        = lfsr_adv[PRBS_TAP_HI] ^ lfsr_adv[PRBS_TAP_LO];
      word_o[i] = fb;
      lfsr_adv  = {lfsr_adv[29:0], fb};
    end
  end

  always_ff @(posedge USER_CLK or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS_SEED;
    end else if (load_i) begin
      lfsr_q <= PRBS_SEED;
    end else if (advance_i) begin
      lfsr_q <= lfsr_adv;
    end
  end

endmodule

// File: rtl/gt_frame_gen.sv
// GT TX frame source: SOP word, FRAME_WORDS-1 PRBS-31 payload words, idle commas between frames.
// Optional single-word bit-0 error injection when GT_FRAME_GEN_ERROR_INJECT_EN is defined.
module gt_frame_gen
  import gt_frame_pkg::*;
#(
  parameter int unsigned TX_DATA_WIDTH        = 64,
  parameter int unsigned FRAME_WORDS          = 512,
  parameter logic [63:0] START_OF_PACKET_CHAR = SOP_CHAR_DEFAULT,
  parameter logic [63:0] IDLE_CHAR            = IDLE_CHAR_DEFAULT,
  parameter logic [30:0] PRBS_SEED            = PRBS_DEFAULT_SEED
) (
  input  logic                       USER_CLK,
  input  logic                       SYSTEM_RESET_N,
  input  logic                       ENABLE_IN,
  input  logic                       TX_READY_IN,
  input  logic                       INJECT_ERROR_IN,
  output logic [TX_DATA_WIDTH-1:0]   TX_DATA_OUT,
  output logic [TX_DATA_WIDTH/8-1:0] TX_CHARISK_OUT,
  output logic [15:0]                FRAME_COUNT_OUT,
  output logic                       BUSY_OUT
);

  localparam int unsigned              KW      = TX_DATA_WIDTH / 8;
  localparam logic [KW-1:0]            K_BYTE0 = KW'(1);
  localparam logic [TX_DATA_WIDTH-1:0] SOP_W   = START_OF_PACKET_CHAR[TX_DATA_WIDTH-1:0];
  localparam logic [TX_DATA_WIDTH-1:0] IDLE_W  = IDLE_CHAR[TX_DATA_WIDTH-1:0];
  localparam logic [15:0]              LAST    = 16'(FRAME_WORDS - 1);

  // Assert asynchronously, release after two USER_CLK edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) rst_sync_q <= 2'b00;
    else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  gt_state_e               state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [TX_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [KW-1:0]           tx_charisk_q, tx_charisk_d;
  logic                    busy_q, busy_d;
  logic [TX_DATA_WIDTH-1:0] prbs_word;
  logic [TX_DATA_WIDTH-1:0] flip;

  gt_prbs31_par #(
    .TX_DATA_WIDTH (TX_DATA_WIDTH),
    .PRBS_SEED     (PRBS_SEED)
  ) u_prbs (
    .USER_CLK  (USER_CLK),
    .rst_n     (rst_n),
    .load_i    ((state_q == StSop) || !TX_READY_IN),
    .advance_i ((state_q == StPayload) && TX_READY_IN),
    .word_o    (prbs_word)
  );

`ifdef GT_FRAME_GEN_ERROR_INJECT_EN
  logic inj_armed_q, inj_armed_d;

  always_comb begin
    inj_armed_d = inj_armed_q;
    if (!TX_READY_IN)                                inj_armed_d = 1'b0;
    else if (inj_armed_q && (state_q == StPayload)) inj_armed_d = 1'b0;
    else if (INJECT_ERROR_IN)                        inj_armed_d = 1'b1;
  end

  always_ff @(posedge USER_CLK or negedge rst_n) begin
    if (!rst_n) inj_armed_q <= 1'b0;
    else        inj_armed_q <= inj_armed_d;
  end

  assign flip = {{(TX_DATA_WIDTH-1){1'b0}}, inj_armed_q && (state_q == StPayload)};
`else
  logic unused_inject;
  assign unused_inject = INJECT_ERROR_IN;
  assign flip          = '0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (ENABLE_IN) state_d = StSop;
      StSop:     state_d = StPayload;
      StPayload: if (cnt_q == LAST) state_d = ENABLE_IN ? StSop : StIdle;
      default:   state_d = StIdle;
    endcase
    if (!TX_READY_IN) state_d = StIdle;
  end

  always_comb begin
    tx_data_d    = IDLE_W;
    tx_charisk_d = K_BYTE0;
    busy_d       = 1'b0;
    cnt_d        = cnt_q;
    frame_cnt_d  = frame_cnt_q;
    unique case (state_q)
      StSop: begin
        tx_data_d   = SOP_W;
        busy_d      = 1'b1;
        cnt_d       = 16'd1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      StPayload: begin
        tx_data_d    = prbs_word ^ flip;
        tx_charisk_d = '0;
        busy_d       = 1'b1;
        cnt_d        = cnt_q + 16'd1;
      end
      default: ;
    endcase
    // Abort: the word in flight is replaced by idle and the frame is not counted.
    if (!TX_READY_IN) begin
      tx_data_d    = IDLE_W;
      tx_charisk_d = K_BYTE0;
      busy_d       = 1'b0;
      cnt_d        = '0;
      frame_cnt_d  = frame_cnt_q;
    end
  end

  always_ff @(posedge USER_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      frame_cnt_q  <= '0;
      tx_data_q    <= IDLE_W;
      tx_charisk_q <= K_BYTE0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_charisk_q <= tx_charisk_d;
      busy_q       <= busy_d;
    end
  end

  assign TX_DATA_OUT     = tx_data_q;
  assign TX_CHARISK_OUT  = tx_charisk_q;
  assign FRAME_COUNT_OUT = frame_cnt_q;
  assign BUSY_OUT        = busy_q;

  // A payload word that looks like a control character means the seed is unusable.
  a_payload_guard: assert property (@(posedge USER_CLK) disable iff (!rst_n)
    (state_q == StPayload) |-> ((prbs_word != SOP_W) && (prbs_word != IDLE_W)));

endmodule

// File: tb/tb_gt_frame_gen.sv
// Directed bench for gt_frame_gen with FRAME_WORDS=4 and 64-bit words.
module tb_gt_frame_gen;

  localparam int unsigned NPAY    = 3;
  localparam logic [63:0] SOP     = 64'h0000_0000_0000_00fb;
  localparam logic [63:0] IDLE    = 64'h0000_0000_0000_00bc;
  // First payload word from seed 7FFFFFFF, worked out by hand from the recurrence.
  localparam logic [63:0] HAND_W0 = 64'h3F00_0000_7000_0000;
`ifdef GT_FRAME_GEN_ERROR_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic        USER_CLK = 1'b0;
  logic        SYSTEM_RESET_N;
  logic        ENABLE_IN;
  logic        TX_READY_IN;
  logic        INJECT_ERROR_IN;
  logic [63:0] TX_DATA_OUT;
  logic [7:0]  TX_CHARISK_OUT;
  logic [15:0] FRAME_COUNT_OUT;
  logic        BUSY_OUT;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_w [NPAY];

  always #5 USER_CLK = ~USER_CLK;

  gt_frame_gen #(
    .TX_DATA_WIDTH (64),
    .FRAME_WORDS   (4)
  ) dut (
    .USER_CLK        (USER_CLK),
    .SYSTEM_RESET_N  (SYSTEM_RESET_N),
    .ENABLE_IN       (ENABLE_IN),
    .TX_READY_IN     (TX_READY_IN),
    .INJECT_ERROR_IN (INJECT_ERROR_IN),
    .TX_DATA_OUT     (TX_DATA_OUT),
    .TX_CHARISK_OUT  (TX_CHARISK_OUT),
    .FRAME_COUNT_OUT (FRAME_COUNT_OUT),
    .BUSY_OUT        (BUSY_OUT)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_data"}, TX_DATA_OUT, IDLE);
    chk({tag, "_k"}, 64'(TX_CHARISK_OUT), 64'h01);
    chk({tag, "_busy"}, 64'(BUSY_OUT), 64'h0);
  endtask

  task automatic wait_sop(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge USER_CLK);
      if (TX_DATA_OUT === SOP) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL %s: observed no SOP within 12 cycles, expected SOP", tag);
    end
  endtask

  // Called with SOP on the outputs; ENABLE_IN drops once drop_after payload words are seen.
  task automatic check_frame(input logic [15:0] cnt, input bit inj, input int drop_after);
    logic [63:0] e;
    chk("sop_data", TX_DATA_OUT, SOP);
    chk("sop_k", 64'(TX_CHARISK_OUT), 64'h01);
    chk("sop_count", 64'(FRAME_COUNT_OUT), 64'(cnt));
    chk("sop_busy", 64'(BUSY_OUT), 64'h1);
    if (drop_after == 0) ENABLE_IN = 1'b0;
    for (int w = 0; w < int'(NPAY); w++) begin
      @(negedge USER_CLK);
      e = exp_w[w];
      if (inj && w == 0) e[0] = ~e[0];
      chk("pay_data", TX_DATA_OUT, e);
      chk("pay_k", 64'(TX_CHARISK_OUT), 64'h00);
      chk("pay_busy", 64'(BUSY_OUT), 64'h1);
      if (w == 0) chk("pay0_hand", TX_DATA_OUT, HAND_W0 ^ {63'b0, inj});
      if (drop_after == w + 1) ENABLE_IN = 1'b0;
    end
  endtask

  initial begin
    // Reference PRBS-31 as a bit recurrence x[k] = x[k-31] ^ x[k-28], 31 ones of history.
    bit hist [31 + 64*NPAY];
    for (int i = 0; i < 31; i++) hist[i] = 1'b1;
    for (int j = 31; j < 31 + 64*int'(NPAY); j++) hist[j] = hist[j-31] ^ hist[j-28];
    for (int n = 0; n < int'(NPAY); n++)
      for (int i = 0; i < 64; i++) exp_w[n][i] = hist[31 + 64*n + i];

    SYSTEM_RESET_N  = 1'b0;
    ENABLE_IN       = 1'b0;
    TX_READY_IN     = 1'b1;
    INJECT_ERROR_IN = 1'b0;
    repeat (3) @(negedge USER_CLK);
    chk_idle("reset");
    chk("reset_count", 64'(FRAME_COUNT_OUT), 64'h0);
    SYSTEM_RESET_N = 1'b1;
    repeat (4) @(negedge USER_CLK);
    chk_idle("post_release");

    // Two back-to-back frames, then a third with ENABLE_IN dropped after the first payload word.
    ENABLE_IN = 1'b1;
    wait_sop("frame1");
    check_frame(16'd1, 1'b0, -1);
    @(negedge USER_CLK);
    check_frame(16'd2, 1'b0, -1);
    @(negedge USER_CLK);
    check_frame(16'd3, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge USER_CLK);
      chk_idle("after_drop");
    end

    // One-cycle TX_READY_IN drop mid-payload aborts; the next frame restarts from the seed.
    ENABLE_IN = 1'b1;
    wait_sop("abort_sop");
    chk("abort_sop_count", 64'(FRAME_COUNT_OUT), 64'd4);
    @(negedge USER_CLK);
    chk("abort_pay0", TX_DATA_OUT, exp_w[0]);
    TX_READY_IN = 1'b0;
    @(negedge USER_CLK);
    chk_idle("abort");
    chk("abort_count", 64'(FRAME_COUNT_OUT), 64'd4);
    TX_READY_IN = 1'b1;
    wait_sop("after_abort");
    check_frame(16'd5, 1'b0, 0);
    @(negedge USER_CLK);
    chk_idle("after_frame5");

    // Frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge USER_CLK);
    release dut.frame_cnt_q;
    @(negedge USER_CLK);
    chk("preload_count", 64'(FRAME_COUNT_OUT), 64'hFFFF);
    ENABLE_IN = 1'b1;
    wait_sop("wrap");
    check_frame(16'h0000, 1'b0, 0);
    @(negedge USER_CLK);
    chk_idle("after_wrap");

    // Inject pulses in IDLE (second one absorbed), then two frames.
    INJECT_ERROR_IN = 1'b1;
    @(negedge USER_CLK);
    INJECT_ERROR_IN = 1'b0;
    @(negedge USER_CLK);
    INJECT_ERROR_IN = 1'b1;
    @(negedge USER_CLK);
    INJECT_ERROR_IN = 1'b0;
    ENABLE_IN = 1'b1;
    wait_sop("inject");
    check_frame(16'd1, INJ_EN, -1);
    @(negedge USER_CLK);
    check_frame(16'd2, 1'b0, 1);
    @(negedge USER_CLK);
    chk_idle("after_inject");

    // Asynchronous reset in the middle of a payload.
    ENABLE_IN = 1'b1;
    wait_sop("pre_reset");
    repeat (2) @(negedge USER_CLK);
    SYSTEM_RESET_N = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_count", 64'(FRAME_COUNT_OUT), 64'h0);
    @(negedge USER_CLK);
    SYSTEM_RESET_N = 1'b1;
    wait_sop("after_reset");
    check_frame(16'd1, 1'b0, 0);
    @(negedge USER_CLK);
    chk_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
